// File: rtl/tsqr_r_drain.sv
// Tags the TSQR R-factor stream with (row, col, last), buffers it in a FWFT FIFO and counts emitted tiles.
// Latency: accept -> head visible next cycle; ingress stalls while the FIFO is full, with no pass-through.
module tsqr_r_drain #(
  parameter int BW         = 64,
  parameter int COL_NO     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic [31:0]      io_mx_no,
  input  logic             io_r_vld,
  input  logic [BW-1:0]    io_r_0,
  output logic             io_r_rdy,
  output logic [BW-1:0]    io_out_data,
  output logic [IDX_W-1:0] io_out_row,
  output logic [IDX_W-1:0] io_out_col,
  output logic             io_out_last,
  output logic             io_out_vld,
  input  logic             io_out_rdy,
  output logic [31:0]      io_tile_cnt,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_NO - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [BW-1:0]    data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } elem_t;

  state_t state, state_nxt;
  logic   start;

  elem_t mem [FIFO_DEPTH];
  elem_t head;
  logic [AW:0] wr_ptr, rd_ptr, occ;
  logic fifo_empty, fifo_full, fifo_one;
  logic push, pop;

  logic [IDX_W-1:0] row, col;
  logic             is_last;
  logic [31:0]      mx_lat, in_tiles, tile_cnt;
  logic             ovf;

  // Extra pointer MSB makes the difference an exact occupancy count.
  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));
  assign fifo_one   = (occ == (AW+1)'(1));

  assign io_r_rdy = (state == RUN) && !fifo_full;
  assign push     = io_r_vld && io_r_rdy;
  assign pop      = io_out_vld && io_out_rdy;
  assign is_last  = (row == LAST_IDX) && (col == LAST_IDX);

  // Head fields read zero while empty so every output is quiet after reset.
  assign head        = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign io_out_vld  = !fifo_empty;
  assign io_out_data = head.data;
  assign io_out_row  = head.row;
  assign io_out_col  = head.col;
  assign io_out_last = head.last;

  assign io_tile_cnt = tile_cnt;
  assign io_busy     = (state == RUN) || (state == FLUSH);
  assign io_done     = (state == DONE);
  assign io_ovf      = ovf;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (io_en) begin
          start     = 1'b1;
          state_nxt = (io_mx_no != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (push && is_last && (in_tiles == mx_lat - 32'd1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (fifo_empty || (fifo_one && pop)) state_nxt = DONE;
      end
      DONE: begin
        if (!io_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      row      <= '0;
      col      <= '0;
      mx_lat   <= '0;
      in_tiles <= '0;
      tile_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mx_lat   <= io_mx_no;
        in_tiles <= '0;
        tile_cnt <= '0;
        row      <= '0;
        col      <= '0;
        ovf      <= 1'b0;
      end else begin
        if (io_r_vld && (state != RUN)) ovf <= 1'b1;
        if (push) begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
          // Row-major walk of the upper triangle; the next row starts on its diagonal.
          if (is_last) begin
            row      <= '0;
            col      <= '0;
            in_tiles <= in_tiles + 32'd1;
          end else if (col == LAST_IDX) begin
            row <= row + IDX_W'(1);
            col <= row + IDX_W'(1);
          end else begin
            col <= col + IDX_W'(1);
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
          if (head.last && (tile_cnt != mx_lat)) tile_cnt <= tile_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{data: io_r_0, row: row, col: col, last: is_last};
  end

endmodule

// File: tb/tb_tsqr_r_drain.sv
// Directed bench for tsqr_r_drain (COL_NO=2): expected stream built from accepted data plus the 3-entry tag table.
module tb_tsqr_r_drain;
  localparam int BW = 64, COL_NO = 2, DEPTH = 8, IDX_W = 8;

  logic             clock = 1'b0;
  logic             reset, io_en, io_r_vld, io_r_rdy, io_out_last, io_out_vld, io_out_rdy;
  logic             io_busy, io_done, io_ovf;
  logic [31:0]      io_mx_no, io_tile_cnt;
  logic [BW-1:0]    io_r_0, io_out_data;
  logic [IDX_W-1:0] io_out_row, io_out_col;

  tsqr_r_drain #(.BW(BW), .COL_NO(COL_NO), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .io_en(io_en), .io_mx_no(io_mx_no),
    .io_r_vld(io_r_vld), .io_r_0(io_r_0), .io_r_rdy(io_r_rdy),
    .io_out_data(io_out_data), .io_out_row(io_out_row), .io_out_col(io_out_col),
    .io_out_last(io_out_last), .io_out_vld(io_out_vld), .io_out_rdy(io_out_rdy),
    .io_tile_cnt(io_tile_cnt), .io_busy(io_busy), .io_done(io_done), .io_ovf(io_ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int k_in, n_target, n_pop, cyc, last_pop_cyc, first_done, rdy_mode;
  logic [31:0] exp_tiles;
  logic [63:0] drv_data;
  int tag_row[3]  = '{0, 0, 1};
  int tag_col[3]  = '{0, 1, 1};
  int tag_last[3] = '{0, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge, score any pop, then drive the next inputs #1 after the edge.
  task automatic cycle();
    logic acc, pop;
    exp_t e;
    @(negedge clock);
    acc = io_r_vld && io_r_rdy;
    pop = io_out_vld && io_out_rdy;
    if (io_done && first_done < 0) first_done = cyc;
    if (pop) begin
      if (exp_q.size() == 0) chk("extra_pop", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", io_out_data, e.data);
        chk("out_row", 64'(io_out_row), 64'(e.row));
        chk("out_col", 64'(io_out_col), 64'(e.col));
        chk("out_last", 64'(io_out_last), 64'(e.last));
        chk("tile_cnt_at_pop", 64'(io_tile_cnt), 64'(exp_tiles));
        if (e.last) exp_tiles++;
      end
      n_pop++;
      last_pop_cyc = cyc;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (acc) begin
      e.data = drv_data;
      e.row  = 8'(tag_row[k_in % 3]);
      e.col  = 8'(tag_col[k_in % 3]);
      e.last = (tag_last[k_in % 3] != 0);
      exp_q.push_back(e);
      k_in++;
      drv_data++;
    end
    io_r_vld = (k_in < n_target);
    io_r_0   = drv_data;
    case (rdy_mode)
      0: io_out_rdy = 1'b1;
      1: io_out_rdy = ~io_out_rdy;
      default: io_out_rdy = 1'b0;
    endcase
  endtask

  task automatic start(input logic [31:0] mx, input int target);
    io_en    = 1'b1;
    io_mx_no = mx;
    io_r_vld = 1'b0;
    @(posedge clock);
    #1;
    io_mx_no     = 32'hFFFF_FFFF;  // later changes must be ignored
    k_in         = 0;
    n_target     = target;
    n_pop        = 0;
    cyc          = 0;
    last_pop_cyc = -1;
    first_done   = -1;
    exp_tiles    = 0;
    exp_q.delete();
    io_r_vld = (target > 0);
    io_r_0   = drv_data;
  endtask

  task automatic run_until_done(input int budget);
    while (first_done < 0 && cyc < budget) cycle();
    chk("done_seen", 64'(first_done >= 0), 1);
    chk("done_latency", 64'(first_done), 64'(last_pop_cyc + 1));
    chk("busy_in_done", 64'(io_busy), 0);
    chk("queue_drained", 64'(exp_q.size()), 0);
  endtask

  task automatic stop();
    io_en    = 1'b0;
    io_r_vld = 1'b0;
    @(posedge clock);
    #1;
    chk("done_clears", 64'(io_done), 0);
  endtask

  initial begin
    reset = 1'b0; io_en = 1'b0; io_mx_no = '0; io_r_vld = 1'b0; io_r_0 = '0;
    io_out_rdy = 1'b0; drv_data = 64'd1; rdy_mode = 0;
    k_in = 0; n_target = 0; n_pop = 0; cyc = 0; last_pop_cyc = -1; first_done = -1; exp_tiles = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_r_rdy", 64'(io_r_rdy), 0);
    chk("rst_out_vld", 64'(io_out_vld), 0);
    chk("rst_out_data", io_out_data, 0);
    chk("rst_tile_cnt", 64'(io_tile_cnt), 0);
    chk("rst_busy", 64'(io_busy), 0);
    chk("rst_done", 64'(io_done), 0);
    chk("rst_ovf", 64'(io_ovf), 0);
    reset = 1'b1;

    // Normal flow: two tiles, data 1..6, sink always ready.
    rdy_mode = 0; io_out_rdy = 1'b1;
    start(2, 6);
    chk("t1_busy", 64'(io_busy), 1);
    chk("t1_r_rdy", 64'(io_r_rdy), 1);
    run_until_done(100);
    chk("t1_pops", 64'(n_pop), 6);
    chk("t1_tile_cnt", 64'(io_tile_cnt), 2);
    chk("t1_ovf", 64'(io_ovf), 0);
    stop();

    // Backpressure: sink stalled, FIFO fills at 8, frees one cycle after the first pop.
    rdy_mode = 2; io_out_rdy = 1'b0;
    start(4, 12);
    repeat (12) cycle();
    chk("t2_accepts_at_full", 64'(k_in), 8);
    chk("t2_r_rdy_full", 64'(io_r_rdy), 0);
    rdy_mode = 0; io_out_rdy = 1'b1;
    chk("t2_r_rdy_before_pop", 64'(io_r_rdy), 0);
    cycle();
    chk("t2_r_rdy_after_pop", 64'(io_r_rdy), 1);
    run_until_done(200);
    chk("t2_pops", 64'(n_pop), 12);
    chk("t2_tile_cnt", 64'(io_tile_cnt), 4);
    stop();

    // Zero tiles.
    io_en = 1'b1; io_mx_no = '0; io_r_vld = 1'b0;
    @(posedge clock);
    #1;
    chk("t3_done", 64'(io_done), 1);
    chk("t3_busy", 64'(io_busy), 0);
    chk("t3_r_rdy", 64'(io_r_rdy), 0);
    chk("t3_tile_cnt", 64'(io_tile_cnt), 0);
    @(posedge clock);
    #1;
    chk("t3_r_rdy_hold", 64'(io_r_rdy), 0);
    stop();

    // Reset mid-operation after 4 accepts and 2 pops, then restart with one tile.
    rdy_mode = 2; io_out_rdy = 1'b0;
    start(2, 4);
    while (k_in < 4 && cyc < 50) cycle();
    rdy_mode = 0; io_out_rdy = 1'b1;
    repeat (2) cycle();
    chk("t4_pops_before_rst", 64'(n_pop), 2);
    reset = 1'b0; io_en = 1'b0; io_r_vld = 1'b0;
    @(posedge clock);
    #1;
    chk("t4_out_vld", 64'(io_out_vld), 0);
    chk("t4_tile_cnt", 64'(io_tile_cnt), 0);
    chk("t4_busy", 64'(io_busy), 0);
    reset = 1'b1;
    exp_q.delete();
    start(1, 3);
    run_until_done(100);
    chk("t4_pops", 64'(n_pop), 3);
    chk("t4_tile_cnt_end", 64'(io_tile_cnt), 1);
    stop();

    // Protocol error: valid while idle, cleared on start, set again during FLUSH.
    io_r_vld = 1'b1; io_r_0 = 64'hDEAD;
    @(posedge clock);
    #1;
    io_r_vld = 1'b0;
    chk("t5_ovf_idle", 64'(io_ovf), 1);
    chk("t5_r_rdy_idle", 64'(io_r_rdy), 0);
    rdy_mode = 2; io_out_rdy = 1'b0;
    start(1, 3);
    chk("t5_ovf_cleared", 64'(io_ovf), 0);
    while (k_in < 3 && cyc < 50) cycle();
    chk("t5_busy_flush", 64'(io_busy), 1);
    chk("t5_r_rdy_flush", 64'(io_r_rdy), 0);
    io_r_vld = 1'b1; io_r_0 = 64'd99;
    @(posedge clock);
    #1;
    io_r_vld = 1'b0;
    chk("t5_ovf_flush", 64'(io_ovf), 1);
    rdy_mode = 0; io_out_rdy = 1'b1;
    run_until_done(100);
    chk("t5_pops", 64'(n_pop), 3);
    chk("t5_tile_cnt", 64'(io_tile_cnt), 1);
    chk("t5_ovf_sticky", 64'(io_ovf), 1);
    stop();

    // Wrap-around: six tiles, sink ready every other cycle.
    rdy_mode = 1; io_out_rdy = 1'b1;
    start(6, 18);
    run_until_done(400);
    chk("t6_pops", 64'(n_pop), 18);
    chk("t6_tile_cnt", 64'(io_tile_cnt), 6);
    chk("t6_ovf", 64'(io_ovf), 0);
    stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
